cprs_bfp_pack: RTL

- Downstream of the block-floating-point compressor: consumes its per-RE compressed I/Q words (2*NUM bits) and per-PRB exponent (shift).
- Serialises each PRB as one exponent byte followed by RE_NUM packed I/Q samples, MSB-first, into a gap-free OUT_W-bit word stream for the fronthaul/DMA writer.
- The final partial word of a symbol is zero-padded and flushed.

---
 rtl/cprs_bfp_pack.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cprs_bfp_pack.sv
// cprs_bfp_pack: serialises BFP-compressed PRBs (exponent byte + RE_NUM I/Q
// samples) into a gap-free, MSB-first OUT_W-bit word stream. The last partial
// word of a symbol is zero-padded and flushed in a dedicated FLUSH cycle.
module cprs_bfp_pack #(
  parameter int NUM    = 7,
  parameter int RE_NUM = 12,
  parameter int OUT_W  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_sop,
  input  logic               i_eop,
  input  logic               i_vld,
  input  logic [2*NUM-1:0]   i_dout,
  input  logic [3:0]         i_shift,
  input  logic               i_last_prb,
  input  logic [6:0]         i_slot_idx,
  input  logic [3:0]         i_symb_idx,
  output logic               o_vld,
  output logic               o_sop,
  output logic               o_eop,
  output logic [OUT_W-1:0]   o_data,
  output logic [6:0]         o_slot_idx,
  output logic [3:0]         o_symb_idx,
  output logic [11:0]        o_word_cnt,
  output logic               o_err
);

  localparam int DW     = 2*NUM;
  localparam int FW     = 8 + DW;              // widest append: exponent byte + one RE
  localparam int ACC_W  = OUT_W + FW;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int CNT_W  = $clog2(RE_NUM + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_re_cnt;
  logic               r_in_prb;
  logic               r_first;
  logic [6:0]         r_slot_pend;
  logic [3:0]         r_symb_pend;

  logic               w_start, w_take, w_end, w_full, w_err;
  logic               w_emit, w_first, w_weop;
  logic [FW-1:0]      w_field;
  logic [ACC_W-1:0]   w_ins, w_cat;
  logic [FILL_W-1:0]  w_alen, w_nfill, w_rfill;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [OUT_W-1:0]   w_word;
  logic [6:0]         w_slot;
  logic [3:0]         w_symb;

  // Append-field alignment, word-completion and protocol checks for this cycle
  always_comb begin
    w_start   = i_vld && i_sop && (r_state == S_IDLE);
    // Inputs are packed in RUN or when they open a symbol; FLUSH drops them
    w_take    = i_vld && ((r_state == S_RUN) || w_start);
    w_field   = i_sop ? {4'h0, i_shift, i_dout} : {i_dout, 8'h00};
    w_alen    = i_sop ? FILL_W'(FW) : FILL_W'(DW);
    w_ins     = {w_field, {OUT_W{1'b0}}} >> r_fill;
    w_cat     = r_acc | w_ins;
    w_nfill   = r_fill + w_alen;
    w_full    = (w_nfill >= FILL_W'(OUT_W));
    w_rfill   = w_full ? (w_nfill - FILL_W'(OUT_W)) : w_nfill;
    w_end     = w_take && i_eop && i_last_prb;
    w_cnt_nxt = i_sop ? CNT_W'(1) : (r_re_cnt + CNT_W'(1));
    w_err     = i_vld && (((r_state == S_IDLE) && !i_sop) ||
                          (r_state == S_FLUSH) ||
                          ((r_state == S_RUN) && i_sop && r_in_prb) ||
                          (w_take && i_eop && (w_cnt_nxt != CNT_W'(RE_NUM))));
    w_emit    = (w_take && w_full) || (r_state == S_FLUSH);
    w_word    = (r_state == S_FLUSH) ? r_acc[ACC_W-1 -: OUT_W] : w_cat[ACC_W-1 -: OUT_W];
    w_weop    = (r_state == S_FLUSH) || (w_end && (w_rfill == '0));
    w_first   = r_first || w_start;
    w_slot    = w_start ? i_slot_idx : r_slot_pend;
    w_symb    = w_start ? i_symb_idx : r_symb_pend;
  end

  // Packing FSM: accumulator, fill level and symbol framing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_fill      <= '0;
      r_first     <= 1'b0;
      r_slot_pend <= '0;
      r_symb_pend <= '0;
    end else begin
      case (r_state)
        S_FLUSH: begin
          r_acc   <= '0;
          r_fill  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          if (w_take) begin
            r_acc  <= w_full ? (w_cat << OUT_W) : w_cat;
            r_fill <= w_rfill;
            if (w_end)
              r_state <= (w_rfill != '0) ? S_FLUSH : S_IDLE;
            else
              r_state <= S_RUN;
          end
        end
      endcase
      if (w_start) begin
        r_slot_pend <= i_slot_idx;
        r_symb_pend <= i_symb_idx;
      end
      // Pending-sop flag survives until the symbol's first word goes out
      r_first <= w_first && !w_emit;
    end
  end

  // Registered output word, framing flags, indices and word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld      <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_data     <= '0;
      o_slot_idx <= '0;
      o_symb_idx <= '0;
      o_word_cnt <= '0;
    end else begin
      o_vld <= w_emit;
      o_sop <= w_emit && w_first;
      o_eop <= w_emit && w_weop;
      if (w_emit) begin
        o_data     <= w_word;
        o_word_cnt <= w_first ? 12'd1 : (o_word_cnt + 12'd1);
        if (w_first) begin
          o_slot_idx <= w_slot;
          o_symb_idx <= w_symb;
        end
      end
    end
  end

  // RE counting per PRB and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_re_cnt <= '0;
      r_in_prb <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      if (w_err)
        o_err <= 1'b1;
      if (w_take) begin
        r_re_cnt <= w_cnt_nxt;
        r_in_prb <= !i_eop;
      end
    end
  end

endmodule
